// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   Sequences one UART transmit frame per accepted byte: start bit, DATA_BITS
//   data bits LSB first, an optional parity bit, then STOP_BITS stop bits.
//   Bit timing comes from an external baud tick generator. This block holds
//   that generator in reset while idle, so every frame starts phase-aligned.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> one parity bit (even, or odd when PARITY_ODD=1) follows the
//                  last data bit
//     undefined -> no parity bit; PARITY_ODD is ignored
//
// Ports
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous, active-high
//   tx_data     in   byte to send, sampled on accept
//   tx_valid    in   source has a byte
//   tx_ready    out  controller can accept (accept = tx_valid & tx_ready)
//   baud_done   in   one-cycle bit-period tick from the baud generator
//   baud_rst    out  synchronous clear to the baud generator
//   txd         out  serial line, idle high
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 baud_done,
  output logic                 baud_rst,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [1:0]           stop_cnt;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Holding the baud generator cleared while idle makes it count from 0 on
  // the first START cycle, so the start bit is a full period long.
  assign tx_ready = (state == S_IDLE);
  assign baud_rst = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // txd and frame_done are registered alongside the state so the line level
  // changes on exactly the edge that moves the FSM to the next bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      txd        <= 1'b1;
      frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shift_reg <= tx_data;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            txd       <= 1'b0;
            state     <= S_START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
          end
        end
        S_START: begin
          if (baud_done) begin
            txd       <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              txd   <= parity_bit;
              state <= S_PARITY;
`else
              txd   <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              txd       <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            txd   <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            if (stop_cnt == LAST_STOP) begin
              stop_cnt   <= '0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Scoreboard bench for uart_tx_ctrl. The driver pushes each accepted byte
//   into a queue; a monitor watches txd, finds each start bit, builds the
//   expected frame from the byte and checks every bit period, the control
//   outputs and the frame_done pulse. A free-running baud generator with
//   period T=5 is modelled here, cleared by the DUT's baud_rst.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int T          = 5;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DATA_BITS + P + STOP_BITS;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       baud_done;
  logic       baud_rst;
  logic       txd;
  logic       busy;
  logic       frame_done;
  logic [2:0] baud_cnt = 3'd0;

  int checks = 0;
  int fails  = 0;

  logic [7:0]       exp_q[$];
  logic [NBITS-1:0] exp_frame;
  bit               in_frame  = 1'b0;
  int               cyc       = 0;
  int               gap       = 0;
  int               last_gap  = 0;
  int               frame_num = 0;

  uart_tx_ctrl #(
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .baud_done (baud_done),
    .baud_rst  (baud_rst),
    .txd       (txd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Free-running baud tick generator, period T, held cleared by baud_rst.
  always @(posedge clk) begin
    if (baud_rst === 1'b1)       baud_cnt <= 3'd0;
    else if (baud_cnt == 3'(T-1)) baud_cnt <= 3'd0;
    else                          baud_cnt <= baud_cnt + 3'd1;
  end
  assign baud_done = (baud_rst !== 1'b1) && (baud_cnt == 3'(T-1));

  // Reference frame: start 0, data LSB first, optional parity, stop 1s.
  function automatic logic [NBITS-1:0] model_frame(input logic [7:0] d);
    logic [NBITS-1:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DATA_BITS] = ((($countones(d) % 2) != 0) ^ (PARITY_ODD != 0));
`endif
    for (int s = 0; s < STOP_BITS; s++) f[1+DATA_BITS+P+s] = 1'b1;
    return f;
  endfunction

  // One comparison: counts it, and reports it when it fails.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a byte until the DUT takes it, then record it on the scoreboard.
  // Inputs change 1 ns after posedge, so tx_ready read here is the value the
  // next edge will see.
  task automatic applyStimulus(input logic [7:0] d, input bit hold_valid);
    int waited;
    waited   = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!(tx_ready === 1'b1 && reset == 1'b0)) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        checks++;
        fails++;
        $display("[TB] FAIL accept_timeout: byte %0h not accepted after %0d cycles", d, waited);
        tx_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(d);
    @(posedge clk); #1;
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  // Wait for every queued byte to be fully transmitted.
  task automatic wait_idle();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 || in_frame) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 500) begin
        checks++;
        fails++;
        $display("[TB] FAIL idle_timeout: %0d bytes pending, in_frame=%0d", exp_q.size(), in_frame);
        return;
      end
    end
  endtask

  // Monitor: samples on negedge. Each bit period is checked as a whole
  // (T samples of txd plus the control outputs), then the cycle right after
  // the last stop bit must carry frame_done with tx_ready back high.
  initial begin
    bit         prev_rst;
    logic [T-1:0] samp;
    logic [3:0] ctl;
    logic [3:0] ctl_seen;
    prev_rst = 1'b1;
    samp     = '0;
    ctl_seen = 4'b0100;
    forever begin
      @(negedge clk);
      ctl = {tx_ready, busy, baud_rst, frame_done};
      if (prev_rst) begin
        checkOutput("reset_state", {27'd0, txd, ctl}, 32'h1A);
        in_frame = 1'b0;
        gap      = 0;
      end else begin
        if (!in_frame && txd === 1'b0) begin
          checkOutput("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_frame = model_frame(exp_q.pop_front());
            in_frame  = 1'b1;
            cyc       = 0;
            last_gap  = gap;
            ctl_seen  = 4'b0100;
            frame_num++;
          end
        end
        if (in_frame) begin
          if (cyc < NBITS*T) begin
            samp[cyc % T] = txd;
            if (ctl !== 4'b0100) ctl_seen = ctl;
            if (cyc % T == T-1) begin
              checkOutput($sformatf("frame%0d_bit%0d", frame_num, cyc / T),
                          {27'd0, samp}, {27'd0, {T{exp_frame[cyc / T]}}});
              checkOutput($sformatf("frame%0d_ctrl%0d", frame_num, cyc / T),
                          {28'd0, ctl_seen}, 32'h4);
              ctl_seen = 4'b0100;
            end
            cyc++;
          end else begin
            checkOutput($sformatf("frame%0d_end", frame_num), {27'd0, txd, ctl}, 32'h1B);
            in_frame = 1'b0;
            gap      = 1;
          end
        end else begin
          checkOutput("idle_state", {27'd0, txd, ctl}, 32'h1A);
          gap++;
        end
      end
      prev_rst = reset;
      if (reset) in_frame = 1'b0;
    end
  end

  // Stimulus sequence: reset, single frames, back-to-back, mid-frame input
  // changes, reset mid-frame, then a randomized run.
  initial begin
    logic [7:0] d;
    bit         hold;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus(8'h55, 1'b0);
    wait_idle();
    applyStimulus(8'h07, 1'b0);
    wait_idle();

    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hA3, 1'b0);
    wait_idle();
    checkOutput("b2b_gap", last_gap, 1);

    applyStimulus(8'h3C, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_idle();

    applyStimulus(8'h96, 1'b0);
    repeat (21) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    applyStimulus(8'hFF, 1'b0);
    wait_idle();

    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      applyStimulus(d, hold);
      if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    tx_valid = 1'b0;
    wait_idle();

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
